ledpanel_scan: RTL

Framebuffer and scan engine for the 32x32 HUB75-style RGB LED panel, sitting directly downstream of the CPU memory/IO decoder. It accepts single-cycle pixel writes from the `0x1000_0000` IO window and continuously refreshes the panel. Refresh uses 1/16 row multiplexing and binary-coded-modulation (BCM) bit planes. No backpressure: every write is accepted.

---
 rtl/ledpanel_pkg.sv | 21 ++
 rtl/ledpanel_fb_ram.sv | 29 ++
 rtl/ledpanel_scan.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ledpanel_pkg.sv
// Shared definitions for the HUB75 framebuffer/scan engine: panel geometry,
// scan FSM states and channel truncation.
package ledpanel_pkg;

  localparam int PANEL_W    = 32;
  localparam int PANEL_ROWS = 16;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_ON
  } scan_state_e;

  // Keeps the 'bits' MSBs of an 8-bit channel, right-aligned.
  function automatic logic [7:0] trunc_channel(input logic [7:0] ch, input int bits);
    return ch >> (8 - bits);
  endfunction

endpackage

// File: rtl/ledpanel_fb_ram.sv
// Simple dual-port, read-first framebuffer bank with a registered read port.
// Contents are deliberately not reset so a pixel survives a scan reset.
module ledpanel_fb_ram
  import ledpanel_pkg::*;
#(
  parameter int W  = 12,
  parameter int AW = $clog2(PANEL_W * PANEL_ROWS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ledpanel_scan.sv
// 32x32 HUB75 panel driver: two framebuffer banks (top/bottom half) and a
// 1/16 multiplexed BCM scan engine with fully registered panel outputs.
module ledpanel_scan
  import ledpanel_pkg::*;
#(
  parameter int BITS = 4,
  parameter int UNIT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_enable,
  input  logic [4:0]  wr_addr_x,
  input  logic [4:0]  wr_addr_y,
  input  logic [23:0] wr_rgb_data,
  output logic        PANEL_R0,
  output logic        PANEL_G0,
  output logic        PANEL_B0,
  output logic        PANEL_R1,
  output logic        PANEL_G1,
  output logic        PANEL_B1,
  output logic        PANEL_A,
  output logic        PANEL_B,
  output logic        PANEL_C,
  output logic        PANEL_D,
  output logic        PANEL_CLK,
  output logic        PANEL_STB,
  output logic        PANEL_OE,
  output logic        frame_start
);

  localparam int WW  = 3 * BITS;
  localparam int CW0 = 3 * BITS + $clog2(UNIT);
  localparam int CW  = (CW0 < 7) ? 7 : CW0;
  localparam int PW  = (BITS > 1) ? $clog2(BITS) : 1;

  scan_state_e   state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [CW-1:0] on_last;

  logic          oe_q, oe_d, stb_q, stb_d, pclk_q, pclk_d, fs_q, fs_d;
  logic [3:0]    rowsel_q, rowsel_d;
  logic [2:0]    rgb0_q, rgb0_d, rgb1_q, rgb1_d;

  logic [WW-1:0]   wr_word;
  logic [8:0]      rd_addr;
  logic [4:0]      rd_col;
  logic [WW-1:0]   rd_word [2];
  logic [BITS-1:0] ch_r [2];
  logic [BITS-1:0] ch_g [2];
  logic [BITS-1:0] ch_b [2];

  assign wr_word = {BITS'(trunc_channel(wr_rgb_data[23:16], BITS)),
                    BITS'(trunc_channel(wr_rgb_data[15:8], BITS)),
                    BITS'(trunc_channel(wr_rgb_data[7:0], BITS))};

  // Address follows the *next* cycle so data is ready when the RGB flops load:
  // FETCH reads column 31, each odd SHIFT cycle reads the following column.
  assign rd_col  = (state_d == ST_SHIFT) ? (5'd31 - 5'((cnt_d + 1'b1) >> 1)) : 5'd31;
  assign rd_addr = {row_d, rd_col};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      ledpanel_fb_ram #(.W(WW)) u_ram (
        .clk     (clk),
        .wr_en   (wr_enable && (wr_addr_y[4] == 1'(gi))),
        .wr_addr ({wr_addr_y[3:0], wr_addr_x}),
        .wr_data (wr_word),
        .rd_addr (rd_addr),
        .rd_data (rd_word[gi])
      );
      assign ch_r[gi] = rd_word[gi][3*BITS-1:2*BITS];
      assign ch_g[gi] = rd_word[gi][2*BITS-1:BITS];
      assign ch_b[gi] = rd_word[gi][BITS-1:0];
    end
  endgenerate

  assign on_last = (CW'(UNIT) << plane_q) - 1'b1;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    cnt_d   = cnt_q;
    run_d   = 1'b1;
    if (!run_q) begin
      // First cycle after reset is a clean FETCH of row 0, plane 0.
      state_d = ST_FETCH;
      row_d   = '0;
      plane_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
        ST_SHIFT: begin
          if (cnt_q == CW'(2 * PANEL_W - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BLANK: state_d = ST_LATCH;
        ST_LATCH: begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
        ST_ON: begin
          if (cnt_q == on_last) begin
            state_d = ST_FETCH;
            cnt_d   = '0;
            if (plane_q == PW'(BITS - 1)) begin
              plane_d = '0;
              row_d   = row_q + 1'b1;
            end else begin
              plane_d = plane_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    oe_d     = (state_d != ST_ON);
    stb_d    = (state_d == ST_LATCH);
    pclk_d   = (state_d == ST_SHIFT) && cnt_d[0];
    rowsel_d = (state_d == ST_BLANK) ? row_d : rowsel_q;
    fs_d     = (state_d == ST_FETCH) && (row_d == 4'd0) && (plane_d == '0);
    rgb0_d   = '0;
    rgb1_d   = '0;
    if (state_d == ST_SHIFT) begin
      if (cnt_d[0]) begin
        rgb0_d = rgb0_q;
        rgb1_d = rgb1_q;
      end else begin
        rgb0_d = {ch_r[0][plane_d], ch_g[0][plane_d], ch_b[0][plane_d]};
        rgb1_d = {ch_r[1][plane_d], ch_g[1][plane_d], ch_b[1][plane_d]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      row_q    <= '0;
      plane_q  <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      oe_q     <= 1'b1;
      stb_q    <= 1'b0;
      pclk_q   <= 1'b0;
      fs_q     <= 1'b0;
      rowsel_q <= '0;
      rgb0_q   <= '0;
      rgb1_q   <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      plane_q  <= plane_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      oe_q     <= oe_d;
      stb_q    <= stb_d;
      pclk_q   <= pclk_d;
      fs_q     <= fs_d;
      rowsel_q <= rowsel_d;
      rgb0_q   <= rgb0_d;
      rgb1_q   <= rgb1_d;
    end
  end

  assign {PANEL_R0, PANEL_G0, PANEL_B0} = rgb0_q;
  assign {PANEL_R1, PANEL_G1, PANEL_B1} = rgb1_q;
  assign {PANEL_D, PANEL_C, PANEL_B, PANEL_A} = rowsel_q;
  assign PANEL_CLK   = pclk_q;
  assign PANEL_STB   = stb_q;
  assign PANEL_OE    = oe_q;
  assign frame_start = fs_q;

endmodule
